// File: rtl/agc_norm_unpack.sv
// agc_norm_unpack
// Takes a snapshot of the per-antenna FFT block-AGC exponents on the first
// beat of a symbol. A serial search then finds the minimum exponent of each
// antenna group, and the block publishes per-group bases and per-entry shifts
// relative to the group minimum. The CPRI payload goes through a fixed-latency
// delay line, so the shifts are published one cycle before the first delayed
// beat of the symbol.
// Build option: define AGC_SHIFT_SAT_EN to clamp every shift to SHIFT_MAX and
// add the o_shift_sat flag.

module agc_norm_unpack #(
    parameter int CHANNELS  = 8,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 7,
    parameter int AGC_W     = 8,
    parameter int NUM_AGC   = 64,
    parameter int GROUPS    = 2,
    parameter int SHIFT_MAX = 15
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [CHANNELS*DATA_W-1:0] i_cpri_data,
    input  logic [CHANNELS*ADDR_W-1:0] i_cpri_addr,
    input  logic [CHANNELS-1:0]        i_cpri_last,
    input  logic                       i_rvalid,
    input  logic [NUM_AGC*AGC_W-1:0]   i_agc,
    input  logic                       i_symb_eop,
    output logic [GROUPS*AGC_W-1:0]    o_agc_base,
    output logic [NUM_AGC*AGC_W-1:0]   o_agc_shift,
    output logic                       o_agc_vld,
    output logic [CHANNELS*DATA_W-1:0] o_tx_data,
    output logic [CHANNELS*ADDR_W-1:0] o_tx_addr,
    output logic [CHANNELS-1:0]        o_tx_last,
    output logic                       o_tx_vld,
`ifdef AGC_SHIFT_SAT_EN
    output logic                       o_shift_sat,
`endif
    output logic                       o_busy
);

    // Search steps per symbol; each step visits one entry of every group.
    localparam int DEPTH = NUM_AGC / GROUPS;
    // Delay-line length: DEPTH search steps plus accept, publish and the
    // one-cycle lead of o_agc_vld over the first delayed beat.
    localparam int LAT   = DEPTH + 3;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

`ifdef AGC_SHIFT_SAT_EN
    localparam logic [AGC_W-1:0] SAT_LIM = AGC_W'(SHIFT_MAX);
`endif

    // Parameter sanity checks at elaboration time.
    if ((NUM_AGC % GROUPS) != 0) begin : g_bad_num_agc
        $error("agc_norm_unpack: NUM_AGC must be a multiple of GROUPS");
    end
    if ((SHIFT_MAX < 0) || (SHIFT_MAX >= (1 << AGC_W))) begin : g_bad_shift_max
        $error("agc_norm_unpack: SHIFT_MAX must fit in AGC_W bits");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        PUBLISH = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             eop_seen;
    logic [AGC_W-1:0] snap      [NUM_AGC];
    logic [AGC_W-1:0] grp_min   [GROUPS];
    logic [AGC_W-1:0] cand      [GROUPS];
    logic [AGC_W-1:0] shift_nxt [NUM_AGC];
`ifdef AGC_SHIFT_SAT_EN
    logic             any_sat;
`endif

    logic [CHANNELS*DATA_W-1:0] dl_data [LAT];
    logic [CHANNELS*ADDR_W-1:0] dl_addr [LAT];
    logic [CHANNELS-1:0]        dl_last [LAT];
    logic                       dl_vld  [LAT];

    // Select the snapshot entries visited by the current search step, one per group.
    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            cand[g] = '0;
            for (int s = 0; s < DEPTH; s++) begin
                if (cnt == CNT_W'(s)) begin
                    cand[g] = snap[s*GROUPS + g];
                end
            end
        end
    end

    // Compute each entry's shift against its group minimum. This cannot underflow because the minimum is drawn from the same snapshot.
    always_comb begin
`ifdef AGC_SHIFT_SAT_EN
        any_sat = 1'b0;
`endif
        for (int k = 0; k < NUM_AGC; k++) begin
            shift_nxt[k] = snap[k] - grp_min[k % GROUPS];
`ifdef AGC_SHIFT_SAT_EN
            if (shift_nxt[k] > SAT_LIM) begin
                shift_nxt[k] = SAT_LIM;
                any_sat      = 1'b1;
            end
`endif
        end
    end

    // Symbol FSM: snapshot, serial min search, publish, then hold until end of symbol.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            eop_seen    <= 1'b0;
            o_agc_base  <= '0;
            o_agc_shift <= '0;
            o_agc_vld   <= 1'b0;
`ifdef AGC_SHIFT_SAT_EN
            o_shift_sat <= 1'b0;
`endif
            for (int k = 0; k < NUM_AGC; k++) begin
                snap[k] <= '0;
            end
            for (int g = 0; g < GROUPS; g++) begin
                grp_min[g] <= '1;
            end
        end else begin
            o_agc_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rvalid) begin
                        for (int k = 0; k < NUM_AGC; k++) begin
                            snap[k] <= i_agc[k*AGC_W +: AGC_W];
                        end
                        for (int g = 0; g < GROUPS; g++) begin
                            grp_min[g] <= '1;
                        end
                        cnt      <= '0;
                        eop_seen <= 1'b0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    for (int g = 0; g < GROUPS; g++) begin
                        if (cand[g] < grp_min[g]) begin
                            grp_min[g] <= cand[g];
                        end
                    end
                    if (i_symb_eop) begin
                        eop_seen <= 1'b1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    for (int g = 0; g < GROUPS; g++) begin
                        o_agc_base[g*AGC_W +: AGC_W] <= grp_min[g];
                    end
                    for (int k = 0; k < NUM_AGC; k++) begin
                        o_agc_shift[k*AGC_W +: AGC_W] <= shift_nxt[k];
                    end
                    o_agc_vld <= 1'b1;
`ifdef AGC_SHIFT_SAT_EN
                    o_shift_sat <= any_sat;
`endif
                    eop_seen <= 1'b0;
                    state    <= (eop_seen || i_symb_eop) ? IDLE : HOLD;
                end
                HOLD: begin
                    if (i_symb_eop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fixed-latency payload delay line. It advances every cycle, independent of the FSM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < LAT; i++) begin
                dl_data[i] <= '0;
                dl_addr[i] <= '0;
                dl_last[i] <= '0;
                dl_vld[i]  <= 1'b0;
            end
        end else begin
            dl_data[0] <= i_cpri_data;
            dl_addr[0] <= i_cpri_addr;
            dl_last[0] <= i_cpri_last;
            dl_vld[0]  <= i_rvalid;
            for (int i = 1; i < LAT; i++) begin
                dl_data[i] <= dl_data[i-1];
                dl_addr[i] <= dl_addr[i-1];
                dl_last[i] <= dl_last[i-1];
                dl_vld[i]  <= dl_vld[i-1];
            end
        end
    end

    assign o_tx_data = dl_data[LAT-1];
    assign o_tx_addr = dl_addr[LAT-1];
    assign o_tx_last = dl_last[LAT-1];
    assign o_tx_vld  = dl_vld[LAT-1];
    assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_agc_norm_unpack.sv
// tb_agc_norm_unpack
// Randomised self-checking bench for agc_norm_unpack. The default instance
// is checked against a cycle-indexed history of driven beats and a
// min/difference model of the AGC normalisation. A small second instance
// with GROUPS=4 exercises the grouping rule. Also builds with AGC_SHIFT_SAT_EN.

module tb_agc_norm_unpack;

    localparam int CH    = 8;
    localparam int DW    = 64;
    localparam int AW    = 7;
    localparam int GW    = 8;
    localparam int NA    = 64;
    localparam int G     = 2;
    localparam int DEPTH = NA / G;
    localparam int LAT   = DEPTH + 3;
    localparam int PUB   = DEPTH + 2;
    localparam int TXW   = 1 + CH + CH*AW + CH*DW;
    localparam int CH4   = 2;
    localparam int NA4   = 16;
    localparam int G4    = 4;
    localparam int PUB4  = NA4 / G4 + 2;
    localparam int LAT4  = NA4 / G4 + 3;
    localparam int MAXS  = 4000;
`ifdef AGC_SHIFT_SAT_EN
    localparam int SMAX  = 15;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [CH*DW-1:0]     cpri_data;
    logic [CH*AW-1:0]     cpri_addr;
    logic [CH-1:0]        cpri_last;
    logic                 rvalid;
    logic [NA*GW-1:0]     agc;
    logic                 eop;
    logic [G*GW-1:0]      agc_base;
    logic [NA*GW-1:0]     agc_shift;
    logic                 agc_vld;
    logic [CH*DW-1:0]     tx_data;
    logic [CH*AW-1:0]     tx_addr;
    logic [CH-1:0]        tx_last;
    logic                 tx_vld;
    logic                 busy;

    logic [CH4*DW-1:0]    d4_data;
    logic [CH4*AW-1:0]    d4_addr;
    logic [CH4-1:0]       d4_last;
    logic                 d4_rvalid;
    logic [NA4*GW-1:0]    d4_agc;
    logic                 d4_eop;
    logic [G4*GW-1:0]     d4_base;
    logic [NA4*GW-1:0]    d4_shift;
    logic                 d4_vld;
    logic [CH4*DW-1:0]    d4_tx_data;
    logic [CH4*AW-1:0]    d4_tx_addr;
    logic [CH4-1:0]       d4_tx_last;
    logic                 d4_tx_vld;
    logic                 d4_busy;
`ifdef AGC_SHIFT_SAT_EN
    logic                 shift_sat;
    logic                 d4_sat;
`endif

    agc_norm_unpack dut (
        .i_clk(clk), .i_reset(reset),
        .i_cpri_data(cpri_data), .i_cpri_addr(cpri_addr), .i_cpri_last(cpri_last),
        .i_rvalid(rvalid), .i_agc(agc), .i_symb_eop(eop),
        .o_agc_base(agc_base), .o_agc_shift(agc_shift), .o_agc_vld(agc_vld),
        .o_tx_data(tx_data), .o_tx_addr(tx_addr), .o_tx_last(tx_last), .o_tx_vld(tx_vld),
`ifdef AGC_SHIFT_SAT_EN
        .o_shift_sat(shift_sat),
`endif
        .o_busy(busy)
    );

    agc_norm_unpack #(.CHANNELS(CH4), .NUM_AGC(NA4), .GROUPS(G4)) dut4 (
        .i_clk(clk), .i_reset(reset),
        .i_cpri_data(d4_data), .i_cpri_addr(d4_addr), .i_cpri_last(d4_last),
        .i_rvalid(d4_rvalid), .i_agc(d4_agc), .i_symb_eop(d4_eop),
        .o_agc_base(d4_base), .o_agc_shift(d4_shift), .o_agc_vld(d4_vld),
        .o_tx_data(d4_tx_data), .o_tx_addr(d4_tx_addr), .o_tx_last(d4_tx_last), .o_tx_vld(d4_tx_vld),
`ifdef AGC_SHIFT_SAT_EN
        .o_shift_sat(d4_sat),
`endif
        .o_busy(d4_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic             h_rst  [MAXS];
    logic             h_vld  [MAXS];
    logic [CH*DW-1:0] h_data [MAXS];
    logic [CH*AW-1:0] h_addr [MAXS];
    logic [CH-1:0]    h_last [MAXS];

    // Record what is driven this cycle, then advance to just after the next edge.
    task automatic step();
        h_rst[cyc]  = reset;
        h_vld[cyc]  = rvalid;
        h_data[cyc] = cpri_data;
        h_addr[cyc] = cpri_addr;
        h_last[cyc] = cpri_last;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected delayed beat at step s: the beat driven LAT steps earlier, unless a reset happened in between.
    function automatic logic [TXW-1:0] exp_tx(input int s);
        if (s < LAT) return '0;
        for (int i = s - LAT; i < s; i++) begin
            if (h_rst[i]) return '0;
        end
        return {h_vld[s-LAT], h_last[s-LAT], h_addr[s-LAT], h_data[s-LAT]};
    endfunction

    function automatic logic [CH*DW-1:0] rand_data();
        logic [CH*DW-1:0] d;
        for (int i = 0; i < CH*DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [NA*GW-1:0] rand_agc(input int lo, input int hi);
        logic [NA*GW-1:0] a;
        for (int k = 0; k < NA; k++) a[k*GW +: GW] = GW'($urandom_range(hi, lo));
        return a;
    endfunction

    // Reference: per-group minimum over entries k with k % G == g, and shift = entry - its group minimum.
    task automatic model_agc(input logic [NA*GW-1:0] a, output logic [G*GW-1:0] base,
                             output logic [NA*GW-1:0] shift);
        int mn [G];
        int v, d;
        for (int g = 0; g < G; g++) mn[g] = 255;
        for (int k = 0; k < NA; k++) begin
            v = int'(a[k*GW +: GW]);
            if (v < mn[k % G]) mn[k % G] = v;
        end
        for (int g = 0; g < G; g++) base[g*GW +: GW] = GW'(mn[g]);
        for (int k = 0; k < NA; k++) begin
            d = int'(a[k*GW +: GW]) - mn[k % G];
`ifdef AGC_SHIFT_SAT_EN
            if (d > SMAX) d = SMAX;
`endif
            shift[k*GW +: GW] = GW'(d);
        end
    endtask

    task automatic drive_idle();
        rvalid = 1'b0; cpri_data = '0; cpri_addr = '0; cpri_last = '0; eop = 1'b0;
    endtask

    task automatic drive_beat(input int a, input bit lst);
        rvalid    = 1'b1;
        cpri_data = rand_data();
        cpri_addr = {CH{AW'(a)}};
        cpri_last = lst ? '1 : '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        step();
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if ({agc_base, agc_shift, agc_vld} !== '0) $display("[TB] FAIL reset_agc: got base=%h vld=%b, required all zero", agc_base, agc_vld);
        else n_pass++;
        n_checks++;
        if ({tx_vld, tx_last, tx_addr, tx_data} !== '0) $display("[TB] FAIL reset_tx: got vld=%b addr=%h, required all zero", tx_vld, tx_addr);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", busy);
        else n_pass++;
`ifdef AGC_SHIFT_SAT_EN
        n_checks++;
        if (shift_sat !== 1'b0) $display("[TB] FAIL reset_sat: got %b required 0", shift_sat);
        else n_pass++;
`endif
    endtask

    task automatic test_defaults();
        logic [NA*GW-1:0] a;
        logic [G*GW-1:0]  eb;
        logic [NA*GW-1:0] es;
        logic [GW-1:0]    exp0;
        int tx_cnt, first_tx;
        for (int k = 0; k < NA; k++) a[k*GW +: GW] = GW'(20 + k % 7);
        a[5*GW +: GW]  = 8'd3;
        a[10*GW +: GW] = 8'd4;
        model_agc(a, eb, es);
`ifdef AGC_SHIFT_SAT_EN
        exp0 = 8'd15;
`else
        exp0 = 8'd16;
`endif
        agc = a;
        tx_cnt = 0;
        first_tx = -1;
        for (int rel = 0; rel <= 80; rel++) begin
            if (rel > 0) begin
                n_checks++;
                if ({tx_vld, tx_last, tx_addr, tx_data} !== exp_tx(cyc))
                    $display("[TB] FAIL defaults_tx rel=%0d: got %h required %h", rel, {tx_vld, tx_last, tx_addr, tx_data}, exp_tx(cyc));
                else n_pass++;
                n_checks++;
                if (agc_vld !== (rel == PUB)) $display("[TB] FAIL defaults_vld rel=%0d: got %b required %b", rel, agc_vld, rel == PUB);
                else n_pass++;
                n_checks++;
                if (busy !== (rel < 41)) $display("[TB] FAIL defaults_busy rel=%0d: got %b required %b", rel, busy, rel < 41);
                else n_pass++;
                if (tx_vld) begin
                    if (first_tx < 0) first_tx = rel;
                    tx_cnt++;
                end
                if (rel == PUB) begin
                    n_checks++;
                    if (agc_base !== 16'h0304) $display("[TB] FAIL defaults_base: got %h required 0304", agc_base);
                    else n_pass++;
                    n_checks++;
                    if (agc_shift !== es) $display("[TB] FAIL defaults_shift: got %h required %h", agc_shift, es);
                    else n_pass++;
                    n_checks++;
                    if ({agc_shift[5*GW +: GW], agc_shift[10*GW +: GW], agc_shift[0 +: GW]} !== {8'd0, 8'd0, exp0})
                        $display("[TB] FAIL defaults_shift_pts: got %h %h %h required 00 00 %h", agc_shift[5*GW +: GW], agc_shift[10*GW +: GW], agc_shift[0 +: GW], exp0);
                    else n_pass++;
                end
            end
            if (rel < 40) drive_beat(rel, rel == 39);
            else drive_idle();
            eop = (rel == 40);
            step();
        end
        n_checks++;
        if (tx_cnt !== 40 || first_tx !== LAT) $display("[TB] FAIL defaults_tx_count: got %0d beats first at %0d, required 40 first at %0d", tx_cnt, first_tx, LAT);
        else n_pass++;
    endtask

    task automatic test_short_symbol();
        logic [NA*GW-1:0] a1, a2;
        logic [G*GW-1:0]  eb1, eb2;
        logic [NA*GW-1:0] es1, es2;
        logic             exp_busy;
        a1 = rand_agc(0, 255);
        a2 = rand_agc(100, 140);
        model_agc(a1, eb1, es1);
        model_agc(a2, eb2, es2);
        agc = a1;
        for (int rel = 0; rel <= 76; rel++) begin
            if (rel > 0) begin
                exp_busy = (rel < PUB) || (rel >= 37 && rel < 36 + PUB);
                n_checks++;
                if ({tx_vld, tx_last, tx_addr, tx_data} !== exp_tx(cyc))
                    $display("[TB] FAIL short_tx rel=%0d: got %h required %h", rel, {tx_vld, tx_last, tx_addr, tx_data}, exp_tx(cyc));
                else n_pass++;
                n_checks++;
                if (agc_vld !== (rel == PUB || rel == 36 + PUB)) $display("[TB] FAIL short_vld rel=%0d: got %b", rel, agc_vld);
                else n_pass++;
                n_checks++;
                if (busy !== exp_busy) $display("[TB] FAIL short_busy rel=%0d: got %b required %b", rel, busy, exp_busy);
                else n_pass++;
                if (rel == PUB) begin
                    n_checks++;
                    if ({agc_base, agc_shift} !== {eb1, es1}) $display("[TB] FAIL short_result1: got base %h required %h", agc_base, eb1);
                    else n_pass++;
                end
                if (rel == 36 + PUB) begin
                    n_checks++;
                    if ({agc_base, agc_shift} !== {eb2, es2}) $display("[TB] FAIL short_result2: got base %h required %h", agc_base, eb2);
                    else n_pass++;
                end
            end
            if (rel == 36) agc = a2;
            if (rel < 4 || (rel >= 36 && rel < 40)) drive_beat(rel, 1'b0);
            else drive_idle();
            eop = (rel == 4) || (rel == 40);
            step();
        end
    endtask

    task automatic test_random_symbols();
        logic [NA*GW-1:0] a;
        logic [G*GW-1:0]  eb;
        logic [NA*GW-1:0] es;
        int nb, eop_rel, end_rel, last_rel;
        bit eop0;
        for (int it = 0; it < 8; it++) begin
            for (int p = 0; p < 2; p++) begin
                drive_idle();
                eop = 1'b1;
                step();
                n_checks++;
                if (busy !== 1'b0) $display("[TB] FAIL idle_eop_busy it=%0d: got %b required 0", it, busy);
                else n_pass++;
            end
            a = rand_agc(0, 255);
            model_agc(a, eb, es);
            agc = a;
            nb = $urandom_range(33, 1);
            eop_rel = $urandom_range(60, 1);
            eop0 = ($urandom_range(1, 0) == 1);
            end_rel = (eop_rel < PUB) ? PUB : eop_rel + 1;
            last_rel = ((end_rel > nb + LAT) ? end_rel : nb + LAT) + 2;
            for (int rel = 0; rel <= last_rel; rel++) begin
                if (rel > 0) begin
                    n_checks++;
                    if ({tx_vld, tx_last, tx_addr, tx_data} !== exp_tx(cyc))
                        $display("[TB] FAIL rand_tx it=%0d rel=%0d: got %h required %h", it, rel, {tx_vld, tx_last, tx_addr, tx_data}, exp_tx(cyc));
                    else n_pass++;
                    n_checks++;
                    if (agc_vld !== (rel == PUB)) $display("[TB] FAIL rand_vld it=%0d rel=%0d: got %b", it, rel, agc_vld);
                    else n_pass++;
                    n_checks++;
                    if (busy !== (rel < end_rel)) $display("[TB] FAIL rand_busy it=%0d rel=%0d: got %b required %b", it, rel, busy, rel < end_rel);
                    else n_pass++;
                    if (rel == PUB || rel == last_rel) begin
                        n_checks++;
                        if ({agc_base, agc_shift} !== {eb, es}) $display("[TB] FAIL rand_result it=%0d rel=%0d: got base %h required %h", it, rel, agc_base, eb);
                        else n_pass++;
                    end
                end
                if (rel < nb && (rel == 0 || $urandom_range(1, 0) == 1)) drive_beat(rel, rel == nb - 1);
                else drive_idle();
                eop = (rel == eop_rel) || (rel == 0 && eop0);
                step();
            end
        end
    endtask

    task automatic test_reset_mid_search();
        agc = rand_agc(0, 255);
        for (int rel = 0; rel <= 50; rel++) begin
            if (rel > 0) begin
                n_checks++;
                if ({tx_vld, tx_last, tx_addr, tx_data} !== exp_tx(cyc))
                    $display("[TB] FAIL midrst_tx rel=%0d: got %h required %h", rel, {tx_vld, tx_last, tx_addr, tx_data}, exp_tx(cyc));
                else n_pass++;
                n_checks++;
                if (agc_vld !== 1'b0) $display("[TB] FAIL midrst_vld rel=%0d: got %b required 0", rel, agc_vld);
                else n_pass++;
                n_checks++;
                if (busy !== (rel <= 11)) $display("[TB] FAIL midrst_busy rel=%0d: got %b required %b", rel, busy, rel <= 11);
                else n_pass++;
                if (rel == 12) begin
                    n_checks++;
                    if ({agc_base, agc_shift, tx_vld, tx_last, tx_addr, tx_data} !== '0)
                        $display("[TB] FAIL midrst_outputs: got base=%h tx_vld=%b, required all zero", agc_base, tx_vld);
                    else n_pass++;
`ifdef AGC_SHIFT_SAT_EN
                    n_checks++;
                    if (shift_sat !== 1'b0) $display("[TB] FAIL midrst_sat: got %b required 0", shift_sat);
                    else n_pass++;
`endif
                end
            end
            if (rel <= 10) drive_beat(rel, 1'b0);
            else drive_idle();
            reset = (rel == 11);
            step();
        end
    endtask

    task automatic test_groups4();
        logic [NA4*GW-1:0] a;
        logic [G4*GW-1:0]  eb;
        logic [NA4*GW-1:0] es;
        logic [CH4*DW-1:0] d;
        int mn [G4];
        int df;
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < NA4; k++) a[k*GW +: GW] = (it == 0) ? 8'hFF : GW'($urandom_range(255, 0));
            if (it == 0) a[6*GW +: GW] = 8'h01;
            for (int g = 0; g < G4; g++) mn[g] = 255;
            for (int k = 0; k < NA4; k++) if (int'(a[k*GW +: GW]) < mn[k % G4]) mn[k % G4] = int'(a[k*GW +: GW]);
            for (int g = 0; g < G4; g++) eb[g*GW +: GW] = GW'(mn[g]);
            for (int k = 0; k < NA4; k++) begin
                df = int'(a[k*GW +: GW]) - mn[k % G4];
`ifdef AGC_SHIFT_SAT_EN
                if (df > SMAX) df = SMAX;
`endif
                es[k*GW +: GW] = GW'(df);
            end
            for (int i = 0; i < CH4*DW/32; i++) d[i*32 +: 32] = $urandom;
            d4_agc = a;
            for (int rel = 0; rel <= 14; rel++) begin
                if (rel > 0) begin
                    n_checks++;
                    if (d4_vld !== (rel == PUB4)) $display("[TB] FAIL g4_vld it=%0d rel=%0d: got %b", it, rel, d4_vld);
                    else n_pass++;
                    n_checks++;
                    if (d4_busy !== (rel < 11)) $display("[TB] FAIL g4_busy it=%0d rel=%0d: got %b required %b", it, rel, d4_busy, rel < 11);
                    else n_pass++;
                    n_checks++;
                    if (rel == LAT4) begin
                        if ({d4_tx_vld, d4_tx_last, d4_tx_addr, d4_tx_data} !== {1'b1, 2'b01, {CH4{7'd5}}, d})
                            $display("[TB] FAIL g4_tx it=%0d: got vld=%b addr=%h data=%h required 1 %h %h", it, d4_tx_vld, d4_tx_addr, d4_tx_data, {CH4{7'd5}}, d);
                        else n_pass++;
                    end else begin
                        if (d4_tx_vld !== 1'b0) $display("[TB] FAIL g4_tx_idle it=%0d rel=%0d: got %b required 0", it, rel, d4_tx_vld);
                        else n_pass++;
                    end
                    if (rel == PUB4) begin
                        n_checks++;
                        if ({d4_base, d4_shift} !== {eb, es}) $display("[TB] FAIL g4_result it=%0d: got base %h shift %h required %h %h", it, d4_base, d4_shift, eb, es);
                        else n_pass++;
                        if (it == 0) begin
                            n_checks++;
                            if (d4_base !== 32'hFF01FFFF) $display("[TB] FAIL g4_base_const: got %h required FF01FFFF", d4_base);
                            else n_pass++;
                        end
                    end
                end
                d4_rvalid = (rel == 0);
                d4_data   = (rel == 0) ? d : '0;
                d4_addr   = (rel == 0) ? {CH4{7'd5}} : '0;
                d4_last   = (rel == 0) ? 2'b01 : 2'b00;
                d4_eop    = (rel == 10);
                step();
            end
        end
    endtask

`ifdef AGC_SHIFT_SAT_EN
    task automatic test_shift_sat();
        logic [NA*GW-1:0] a;
        logic [G*GW-1:0]  eb;
        logic [NA*GW-1:0] es;
        int mn [G];
        bit exp_sat;
        for (int cs = 0; cs < 2; cs++) begin
            a = rand_agc(0, (cs == 0) ? 10 : 15);
            if (cs == 0) begin
                a[0 +: GW]     = 8'd0;
                a[30*GW +: GW] = 8'd40;
            end
            model_agc(a, eb, es);
            for (int g = 0; g < G; g++) mn[g] = 255;
            for (int k = 0; k < NA; k++) if (int'(a[k*GW +: GW]) < mn[k % G]) mn[k % G] = int'(a[k*GW +: GW]);
            exp_sat = 1'b0;
            for (int k = 0; k < NA; k++) if (int'(a[k*GW +: GW]) - mn[k % G] > SMAX) exp_sat = 1'b1;
            agc = a;
            for (int rel = 0; rel <= 42; rel++) begin
                if (rel == PUB || rel == 42) begin
                    n_checks++;
                    if ({agc_shift, shift_sat} !== {es, exp_sat}) $display("[TB] FAIL sat_result cs=%0d rel=%0d: got sat=%b required %b", cs, rel, shift_sat, exp_sat);
                    else n_pass++;
                    n_checks++;
                    if (cs == 0 && {agc_shift[30*GW +: GW], shift_sat} !== {8'd15, 1'b1}) $display("[TB] FAIL sat_const: got %h %b required 0f 1", agc_shift[30*GW +: GW], shift_sat);
                    else if (cs == 1 && shift_sat !== 1'b0) $display("[TB] FAIL sat_clear: got %b required 0", shift_sat);
                    else n_pass++;
                end
                if (rel == 0) drive_beat(0, 1'b1);
                else drive_idle();
                eop = (rel == 38);
                step();
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        drive_idle();
        agc = '0;
        d4_data = '0; d4_addr = '0; d4_last = '0; d4_rvalid = 1'b0; d4_agc = '0; d4_eop = 1'b0;
        test_reset();
        test_defaults();
        test_short_symbol();
        test_random_symbols();
        test_reset_mid_search();
        test_groups4();
`ifdef AGC_SHIFT_SAT_EN
        test_shift_sat();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
